// File: rtl/bp_fe_fetch_buffer_if.sv
// Fetch buffer bus: fetch packet input, per-instruction output, occupancy.
// master drives fetch packets and consumes instructions; slave is the buffer.
interface bp_fe_fetch_buffer_if #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2,
  parameter int depth_p       = 4
);
  localparam int cnt_w_lp = $clog2(depth_p+1);

  logic                                   fetch_v_i;
  logic                                   fetch_ready_o;
  logic [vaddr_width_p-1:0]               fetch_pc_i;
  logic [fetch_width_p*instr_width_p-1:0] fetch_instr_i;
  logic [fetch_width_p-1:0]               fetch_mask_i;
  logic                                   fetch_exc_v_i;
  logic [1:0]                             fetch_exc_code_i;
  logic                                   instr_v_o;
  logic                                   instr_ready_i;
  logic [vaddr_width_p-1:0]               instr_pc_o;
  logic [instr_width_p-1:0]               instr_o;
  logic                                   instr_exc_v_o;
  logic [1:0]                             instr_exc_code_o;
  logic [cnt_w_lp-1:0]                    count_o;

  modport master (
    output fetch_v_i, fetch_pc_i, fetch_instr_i, fetch_mask_i,
    output fetch_exc_v_i, fetch_exc_code_i, instr_ready_i,
    input  fetch_ready_o, instr_v_o, instr_pc_o, instr_o,
    input  instr_exc_v_o, instr_exc_code_o, count_o
  );

  modport slave (
    input  fetch_v_i, fetch_pc_i, fetch_instr_i, fetch_mask_i,
    input  fetch_exc_v_i, fetch_exc_code_i, instr_ready_i,
    output fetch_ready_o, instr_v_o, instr_pc_o, instr_o,
    output instr_exc_v_o, instr_exc_code_o, count_o
  );
endinterface

// File: rtl/bp_fe_fetch_buffer.sv
// Fetch buffer: queues fetch packets, emits one instruction per handshake.
// Ports: clk_i, reset_i (sync, active high), flush_i, io (slave bus).
// Optional BP_FE_FETCH_BUFFER_BYPASS_EN: same-cycle output when empty.
module bp_fe_fetch_buffer #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2,
  parameter int depth_p       = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  bp_fe_fetch_buffer_if.slave    io
);
  localparam int idx_w_lp  = $clog2(depth_p);
  localparam int ptr_w_lp  = idx_w_lp + 1;
  localparam int cnt_w_lp  = $clog2(depth_p+1);
  localparam int lane_w_lp = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
  localparam int pkt_w_lp  = fetch_width_p * instr_width_p;

  typedef enum logic {e_run, e_wait} state_e;

  typedef logic [fetch_width_p-1:0] mask_t;
  typedef logic [lane_w_lp-1:0]     lane_t;

  function automatic lane_t low_lane(mask_t m, lane_t from);
    lane_t r;
    r = '0;
    for (int k = fetch_width_p-1; k >= 0; k--)
      if (m[k] && k >= int'(from)) r = lane_t'(k);
    return r;
  endfunction

  function automatic logic any_above(mask_t m, lane_t l);
    logic r;
    r = 1'b0;
    for (int k = 0; k < fetch_width_p; k++)
      if (m[k] && k > int'(l)) r = 1'b1;
    return r;
  endfunction

  state_e state_q, state_d;
  logic [ptr_w_lp-1:0] rptr_q, wptr_q;
  lane_t lane_q, lane_d;

  logic [vaddr_width_p-1:0] pc_q   [depth_p];
  logic [pkt_w_lp-1:0]      ins_q  [depth_p];
  mask_t                    mask_q [depth_p];
  logic                     exc_q  [depth_p];
  logic [1:0]               code_q [depth_p];

  logic [idx_w_lp-1:0] r_idx, w_idx;
  logic empty, full, acc, has_work, push, pop;
  mask_t push_mask;
  lane_t h_lane, sel_lane;
  logic  h_last;
  logic [vaddr_width_p-1:0] sel_pc;
  logic [pkt_w_lp-1:0]      sel_ins;
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
  logic  byp;
  lane_t in_lane;
`endif

  assign r_idx = rptr_q[idx_w_lp-1:0];
  assign w_idx = wptr_q[idx_w_lp-1:0];
  assign empty = rptr_q == wptr_q;
  assign full  = (rptr_q[idx_w_lp] != wptr_q[idx_w_lp]) && (r_idx == w_idx);

  assign io.fetch_ready_o = ~full & (state_q == e_run) & ~flush_i & ~reset_i;
  assign acc      = io.fetch_v_i & io.fetch_ready_o;
  assign has_work = io.fetch_exc_v_i | (|io.fetch_mask_i);

  // lane_q only ever points at or below the head's next set lane
  assign h_lane = low_lane(mask_q[r_idx], lane_q);
  assign h_last = exc_q[r_idx] | ~any_above(mask_q[r_idx], h_lane);

  always_comb begin
    io.instr_v_o        = ~empty;
    io.instr_exc_v_o    = exc_q[r_idx];
    io.instr_exc_code_o = code_q[r_idx];
    sel_pc              = pc_q[r_idx];
    sel_ins             = ins_q[r_idx];
    sel_lane            = exc_q[r_idx] ? '0 : h_lane;
    push                = acc & has_work;
    push_mask           = io.fetch_mask_i;
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    in_lane = low_lane(io.fetch_mask_i, '0);
    byp     = empty & acc & has_work;
    if (byp) begin
      io.instr_v_o        = 1'b1;
      io.instr_exc_v_o    = io.fetch_exc_v_i;
      io.instr_exc_code_o = io.fetch_exc_code_i;
      sel_pc              = io.fetch_pc_i;
      sel_ins             = io.fetch_instr_i;
      sel_lane            = io.fetch_exc_v_i ? '0 : in_lane;
      // consumed lane never enters the buffer
      if (io.instr_ready_i) begin
        push_mask = io.fetch_mask_i & ~(mask_t'(1) << in_lane);
        push      = ~io.fetch_exc_v_i & (|push_mask);
      end
    end
`endif
    io.instr_pc_o = sel_pc + vaddr_width_p'({sel_lane, 2'b00});
    io.instr_o    = sel_ins[sel_lane*instr_width_p +: instr_width_p];
  end

  assign pop = ~empty & io.instr_ready_i & h_last;

  always_comb begin
    lane_d = lane_q;
    if (~empty & io.instr_ready_i)
      lane_d = h_last ? '0 : lane_t'(h_lane + lane_t'(1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_run:  if (acc & io.fetch_exc_v_i) state_d = e_wait;
      e_wait: state_d = e_wait;
      default: state_d = e_run;
    endcase
  end

  assign io.count_o = cnt_w_lp'(wptr_q - rptr_q);

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      lane_q  <= '0;
      state_q <= e_run;
    end else begin
      rptr_q  <= rptr_q + ptr_w_lp'(pop);
      wptr_q  <= wptr_q + ptr_w_lp'(push);
      lane_q  <= lane_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_q[w_idx]   <= io.fetch_pc_i;
      ins_q[w_idx]  <= io.fetch_instr_i;
      mask_q[w_idx] <= push_mask;
      exc_q[w_idx]  <= io.fetch_exc_v_i;
      code_q[w_idx] <= io.fetch_exc_code_i;
    end
  end
endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Random-stimulus bench for bp_fe_fetch_buffer against a queue model.
// Model: flat queue of pending instructions, tagged with packet end.
module tb_bp_fe_fetch_buffer;
  localparam int VA = 39;
  localparam int IW = 32;
  localparam int FW = 2;
  localparam int D  = 4;

  typedef struct {
    logic [VA-1:0] pc;
    logic [IW-1:0] ins;
    logic          exc;
    logic [1:0]    code;
    logic          last;
  } item_t;

  logic clk = 1'b0;
  logic reset_i;
  logic flush_i;

  bp_fe_fetch_buffer_if #(
    .vaddr_width_p(VA), .instr_width_p(IW),
    .fetch_width_p(FW), .depth_p(D)
  ) bus ();

  bp_fe_fetch_buffer #(
    .vaddr_width_p(VA), .instr_width_p(IW),
    .fetch_width_p(FW), .depth_p(D)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .flush_i(flush_i),
    .io     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  item_t q[$];
  item_t nq[$];
  int    nent;
  bit    wait_st;

  task automatic build_new();
    item_t it;
    int    hi;
    nq.delete();
    hi = -1;
    for (int k = 0; k < FW; k++)
      if (bus.fetch_mask_i[k]) hi = k;
    if (bus.fetch_exc_v_i) begin
      it.pc   = bus.fetch_pc_i;
      it.ins  = bus.fetch_instr_i[IW-1:0];
      it.exc  = 1'b1;
      it.code = bus.fetch_exc_code_i;
      it.last = 1'b1;
      nq.push_back(it);
    end else begin
      for (int k = 0; k < FW; k++)
        if (bus.fetch_mask_i[k]) begin
          it.pc   = bus.fetch_pc_i + VA'(4*k);
          it.ins  = bus.fetch_instr_i[k*IW +: IW];
          it.exc  = 1'b0;
          it.code = 2'b00;
          it.last = (k == hi);
          nq.push_back(it);
        end
    end
  endtask

  initial begin
    logic [63:0] r64;
    bit    exp_ready, exp_v, acc, byp;
    item_t head, popped;
    int    rdy_pct;

    reset_i = 1'b1;
    flush_i = 1'b0;
    bus.fetch_v_i        = 1'b0;
    bus.fetch_pc_i       = '0;
    bus.fetch_instr_i    = '0;
    bus.fetch_mask_i     = '0;
    bus.fetch_exc_v_i    = 1'b0;
    bus.fetch_exc_code_i = '0;
    bus.instr_ready_i    = 1'b0;
    nent    = 0;
    wait_st = 1'b0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rdy_pct = ((cyc % 200) < 50) ? 10 : 65;
      reset_i = ($urandom_range(299) == 0);
      flush_i = ($urandom_range(24) == 0);
      bus.fetch_v_i = ($urandom_range(99) < 70);
      r64 = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) r64 = 64'h7F_FFFF_FFFC;
      bus.fetch_pc_i       = r64[VA-1:0];
      bus.fetch_instr_i    = {$urandom(), $urandom()};
      bus.fetch_mask_i     = FW'($urandom());
      bus.fetch_exc_v_i    = ($urandom_range(9) == 0);
      bus.fetch_exc_code_i = 2'($urandom());
      bus.instr_ready_i    = ($urandom_range(99) < rdy_pct);
      #1;

      exp_ready = !reset_i && !flush_i && !wait_st && (nent < D);
      acc = bus.fetch_v_i && exp_ready;
      build_new();
      byp = 1'b0;
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
      byp = (q.size() == 0) && acc && (nq.size() > 0);
`endif
      exp_v = (q.size() > 0) || byp;

      check("fetch_ready", 64'(bus.fetch_ready_o), 64'(exp_ready));
      check("count", 64'(bus.count_o), 64'(nent));
      check("instr_v", 64'(bus.instr_v_o), 64'(exp_v));
      if (exp_v) begin
        head = byp ? nq[0] : q[0];
        check("instr_pc", 64'(bus.instr_pc_o), 64'(head.pc));
        check("exc_v", 64'(bus.instr_exc_v_o), 64'(head.exc));
        if (head.exc)
          check("exc_code", 64'(bus.instr_exc_code_o), 64'(head.code));
        else
          check("instr", 64'(bus.instr_o), 64'(head.ins));
      end

      @(posedge clk);
      if (reset_i || flush_i) begin
        q.delete();
        nent    = 0;
        wait_st = 1'b0;
      end else begin
        if (exp_v && bus.instr_ready_i && !byp) begin
          popped = q.pop_front();
          if (popped.last) nent--;
        end
        if (acc) begin
          if (bus.fetch_exc_v_i) wait_st = 1'b1;
          if (byp && bus.instr_ready_i) void'(nq.pop_front());
          if (nq.size() > 0) begin
            foreach (nq[i]) q.push_back(nq[i]);
            nent++;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bp_fe_fetch_buffer.md
BP_FE_FETCH_BUFFER -- requirements
Module: bp_fe_fetch_buffer

Interface
REQ-001 Parameter: vaddr_width_p, 39, virtual address width.
REQ-002 Parameter: instr_width_p, 32, instruction width; lane stride is 4 bytes.
REQ-003 Parameter: fetch_width_p, 2, instructions per fetch packet; legal values 1, 2 or 4.
REQ-004 Parameter: depth_p, 4, packet entries; power of two, at least 2.
REQ-005 Port: clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port: reset_i  in  1  synchronous, active-high reset.
REQ-007 Port: flush_i  in  1  redirect; discards all buffered state.
REQ-008 Port: fetch_v_i / fetch_ready_o  in/out  1/1  input packet valid-ready handshake.
REQ-009 Port: fetch_pc_i  in  vaddr_width_p  PC of lane 0.
REQ-010 Port: fetch_instr_i  in  fetch_width_p*instr_width_p  lane k in bits [k*instr_width_p +: instr_width_p].
REQ-011 Port: fetch_mask_i  in  fetch_width_p  per-lane valid; any pattern legal.
REQ-012 Port: fetch_exc_v_i / fetch_exc_code_i  in/in  1/2  packet is an exception; code.
REQ-013 Port: instr_v_o / instr_ready_i  out/in  1/1  output valid-ready handshake, one instruction per transfer.
REQ-014 Port: instr_pc_o, instr_o  out  vaddr_width_p, instr_width_p  PC and instruction of the head lane.
REQ-015 Port: instr_exc_v_o / instr_exc_code_o  out  1/2  head entry is an exception; code.
REQ-016 Port: count_o  out  $clog2(depth_p+1)  number of occupied packet entries.

Function
REQ-017 Input accept: fetch_v_i & fetch_ready_o; fetch_ready_o = ~full & state==e_run & ~flush_i.
REQ-018 A packet with fetch_mask_i == 0 and fetch_exc_v_i == 0 is accepted and dropped; it is not stored.
REQ-019 An exception packet is stored as one entry with mask ignored; it emits exactly one output with instr_exc_v_o=1 and instr_pc_o=fetch_pc_i.
REQ-020 Output order: strictly FIFO by packet, then ascending lane index; lanes with mask bit 0 are skipped with no bubble cycle.
REQ-021 Lane k PC: fetch_pc_i + 4*k, modulo 2^vaddr_width_p (wrap-around).
REQ-022 Head packet pops on the handshake of its highest set lane; the lane pointer then returns to the lowest set lane of the next entry.
REQ-023 Storage: circular buffer with read/write pointers of $clog2(depth_p)+1 bits; the extra bit distinguishes full from empty.
REQ-024 Push and pop in the same cycle leave count_o unchanged; when full, a same-cycle pop does not raise fetch_ready_o in that cycle.
REQ-025 State machine e_run/e_wait: e_run -> e_wait on acceptance of an exception packet; e_wait -> e_run only on flush_i.
REQ-026 e_wait: fetch_ready_o=0; entries already buffered, including the exception, still drain.
REQ-027 flush_i: an output handshake in the same cycle completes; next cycle all entries are empty, lane pointer is 0, count_o=0, state is e_run; input in the flush cycle is ignored.
REQ-028 Outputs are undefined when instr_v_o=0; instr_v_o=1 whenever at least one entry exists, never when count_o=0 (except under REQ-032).

Reset
REQ-029 reset_i high: next cycle instr_v_o=0, count_o=0, pointers=0, lane pointer=0, state=e_run.
REQ-030 fetch_ready_o=0 while reset_i is high; fetch_ready_o=1 in the first cycle after deassertion.
REQ-031 Reset mid-operation discards all entries and overrides a simultaneous flush_i or handshake.

Configuration
REQ-032 BP_FE_FETCH_BUFFER_BYPASS_EN defined: with the buffer empty and state e_run, an accepted packet drives its lowest set lane (or its exception) onto the outputs in the same cycle. If that lane handshakes, it is consumed and only the remaining lanes are stored; if none remain, nothing is stored.
REQ-033 BP_FE_FETCH_BUFFER_BYPASS_EN undefined: the earliest instr_v_o for a packet accepted in cycle N is cycle N+1; no combinational path runs from fetch_* to instr_*.

Verification (fetch_width_p=2, depth_p=4)
REQ-034 pc=0x1000, mask=2'b11, instr_ready_i=1 -> outputs (0x1000, lane0) then (0x1004, lane1) on consecutive cycles; count_o 1 -> 0.
REQ-035 Five packets with mask=2'b11 and instr_ready_i=0 -> fetch_ready_o=0 after the 4th; count_o=4; the 5th is accepted one cycle after the first pop.
REQ-036 Packet mask=2'b10 at pc=0x2000, then an exception packet with code 2 at pc=0x2008 -> out 0x2004, then exc_v=1 code=2 pc=0x2008; fetch_ready_o stays 0 until flush_i.
REQ-037 Three entries buffered, flush_i pulsed with instr_ready_i=1 -> one transfer in the flush cycle; next cycle count_o=0, instr_v_o=0, fetch_ready_o=1.
REQ-038 pc=0x7F_FFFF_FFFC, mask=2'b11 -> lane1 PC=0x0.
REQ-039 With BYPASS_EN, buffer empty, mask=2'b01, instr_ready_i=1 -> instr_v_o=1 in the accept cycle; count_o stays 0. Without BYPASS_EN -> instr_v_o=1 one cycle later.
